// File: rtl/cpu_defs.sv
// Shared definitions for the E-stage multiply/divide unit: op encodings,
// sequencer state type and default latencies.
package cpu_defs;

    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MTHI  = 3'd4;
    localparam logic [2:0] MD_MTLO  = 3'd5;

    localparam int unsigned MD_MULT_CYCLES_DEF = 5;
    localparam int unsigned MD_DIV_CYCLES_DEF  = 10;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } md_state_t;

    // Long ops are exactly the encodings 0..3.
    function automatic logic md_is_long(input logic [2:0] op);
        return (op[2] == 1'b0);
    endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational 64-bit {hi,lo} result for mult/multu/div/divu.
// wr_en is low for divide-by-zero and for ops that produce no result.
module md_arith
    import cpu_defs::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] result,
    output logic        wr_en
);

    logic        is_sdiv;
    logic [31:0] div_n;
    logic [31:0] div_d;
    logic [31:0] div_d_safe;
    logic [31:0] quo_mag;
    logic [31:0] rem_mag;

    // One unsigned divider serves both div and divu; signed div works on
    // magnitudes, so 0x80000000 / -1 wraps back to 0x80000000 with rem 0.
    always_comb begin
        is_sdiv    = (op == MD_DIV);
        div_n      = (is_sdiv && a[31]) ? -a : a;
        div_d      = (is_sdiv && b[31]) ? -b : b;
        div_d_safe = (div_d == '0) ? 32'd1 : div_d;
        quo_mag    = div_n / div_d_safe;
        rem_mag    = div_n % div_d_safe;
    end

    always_comb begin
        result = '0;
        wr_en  = 1'b0;
        case (op)
            MD_MULT: begin
                result = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
                wr_en  = 1'b1;
            end
            MD_MULTU: begin
                result = {32'h0, a} * {32'h0, b};
                wr_en  = 1'b1;
            end
            MD_DIV: begin
                result[63:32] = a[31] ? -rem_mag : rem_mag;
                result[31:0]  = (a[31] ^ b[31]) ? -quo_mag : quo_mag;
                wr_en         = (b != '0);
            end
            MD_DIVU: begin
                result = {rem_mag, quo_mag};
                wr_en  = (b != '0);
            end
            default: begin
                result = '0;
                wr_en  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/md_ctrl.sv
// Multiply/divide sequencer beside the E-stage ALU: owns HI/LO, models
// multi-cycle latency with a busy counter and requests D-stage stalls.
module md_ctrl
    import cpu_defs::*;
#(
    parameter int unsigned MULT_CYCLES = MD_MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        md_use_D,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        stall_req
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    md_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;
    logic [31:0]      hi_nxt_q, hi_nxt_d;
    logic [31:0]      lo_nxt_q, lo_nxt_d;

    logic [63:0]      arith_result;
    logic             arith_wr_en;
    logic             long_start;

    md_arith u_arith (
        .op     (op),
        .a      (a),
        .b      (b),
        .result (arith_result),
        .wr_en  (arith_wr_en)
    );

    assign long_start = start & md_is_long(op);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            hi_nxt_q <= '0;
            lo_nxt_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            hi_nxt_q <= hi_nxt_d;
            lo_nxt_q <= lo_nxt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        hi_nxt_d = hi_nxt_q;
        lo_nxt_d = lo_nxt_q;
        case (state_q)
            IDLE: begin
                if (long_start) begin
                    // Divide-by-zero re-commits the current HI/LO so the
                    // completion path needs no separate write-enable flop.
                    hi_nxt_d = arith_wr_en ? arith_result[63:32] : hi_q;
                    lo_nxt_d = arith_wr_en ? arith_result[31:0]  : lo_q;
                    cnt_d    = (op == MD_MULT || op == MD_MULTU) ? MULT_CNT : DIV_CNT;
                    state_d  = BUSY;
                end else if (start && op == MD_MTHI) begin
                    hi_d = a;
                end else if (start && op == MD_MTLO) begin
                    lo_d = a;
                end
            end
            BUSY: begin
                if (cnt_q <= CNT_ONE) begin
                    hi_d    = hi_nxt_q;
                    lo_d    = lo_nxt_q;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        busy      = (state_q == BUSY);
        stall_req = md_use_D & (busy | long_start);
        hi        = hi_q;
        lo        = lo_q;
    end

endmodule

// File: tb/tb_md_ctrl.sv
// Self-checking bench for md_ctrl: directed scenarios plus random traffic
// compared every cycle against an arithmetic model of HI/LO and busy time.
module tb_md_ctrl;

    localparam int unsigned MC = 5;
    localparam int unsigned DC = 10;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        md_use_D;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        stall_req;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: architectural HI/LO, cycles of latency left, pending result.
    logic [31:0] m_hi, m_lo, m_phi, m_plo;
    bit          m_pwe;
    int          m_left;

    md_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .a         (a),
        .b         (b),
        .md_use_D  (md_use_D),
        .busy      (busy),
        .hi        (hi),
        .lo        (lo),
        .stall_req (stall_req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic void model_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                     output logic [31:0] rh, output logic [31:0] rl, output bit we);
        longint      p;
        logic [63:0] u;
        int          sx, sy;
        we = 1'b1;
        rh = '0;
        rl = '0;
        sx = int'(x);
        sy = int'(y);
        case (o)
            3'd0: begin
                p  = longint'(sx) * longint'(sy);
                u  = p;
                rh = u[63:32];
                rl = u[31:0];
            end
            3'd1: begin
                u  = {32'h0, x} * {32'h0, y};
                rh = u[63:32];
                rl = u[31:0];
            end
            3'd2: begin
                if (sy == 0) we = 1'b0;
                else if (x == 32'h8000_0000 && sy == -1) begin
                    rl = 32'h8000_0000;
                    rh = '0;
                end else begin
                    rl = sx / sy;
                    rh = sx % sy;
                end
            end
            3'd3: begin
                if (y == 0) we = 1'b0;
                else begin
                    rl = x / y;
                    rh = x % y;
                end
            end
            default: we = 1'b0;
        endcase
    endfunction

    function automatic bit exp_stall();
        return md_use_D && (m_left > 0 || (start && op <= 3'd3));
    endfunction

    // Advance one clock edge, updating the model from the inputs seen there.
    task automatic step();
        logic [31:0] th, tl;
        bit          twe;
        @(posedge clk);
        if (reset) begin
            m_hi = '0; m_lo = '0; m_left = 0; m_phi = '0; m_plo = '0; m_pwe = 1'b0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0 && m_pwe) begin
                m_hi = m_phi;
                m_lo = m_plo;
            end
        end else if (start) begin
            if (op <= 3'd3) begin
                model_op(op, a, b, th, tl, twe);
                m_phi  = th;
                m_plo  = tl;
                m_pwe  = twe;
                m_left = (op <= 3'd1) ? MC : DC;
            end else if (op == 3'd4) m_hi = a;
            else if (op == 3'd5) m_lo = a;
        end
        #1;
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1; op = o; a = x; b = y;
        step();
        start = 1'b0;
    endtask

    task automatic run_idle(output int n);
        n = 1;
        while (busy === 1'b1 && n < 40) begin
            step();
            if (busy === 1'b1) n++;
        end
        step();
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0; md_use_D = 1'b0;
        step(); step();
        reset = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (hi !== 32'h0) begin n_bad++; $display("FAIL reset_hi: got %h want 0", hi); end
        n_cmp++; if (lo !== 32'h0) begin n_bad++; $display("FAIL reset_lo: got %h want 0", lo); end
        n_cmp++; if (stall_req !== 1'b0) begin n_bad++; $display("FAIL reset_stall: got %b want 0", stall_req); end
    endtask

    task automatic test_mult();
        int n;
        issue(3'd0, 32'hFFFF_FFFE, 32'd3);
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL mult_busy_rise: got %b want 1", busy); end
        n_cmp++; if (hi !== 32'h0) begin n_bad++; $display("FAIL mult_hi_early: got %h want 0", hi); end
        run_idle(n);
        n_cmp++; if (n != MC) begin n_bad++; $display("FAIL mult_busy_len: got %0d want %0d", n, MC); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mult_busy_fall: got %b want 0", busy); end
        n_cmp++; if (hi !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL mult_hi: got %h want ffffffff", hi); end
        n_cmp++; if (lo !== 32'hFFFF_FFFA) begin n_bad++; $display("FAIL mult_lo: got %h want fffffffa", lo); end
    endtask

    task automatic test_multu();
        int n;
        issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_idle(n);
        n_cmp++; if (n != MC) begin n_bad++; $display("FAIL multu_busy_len: got %0d want %0d", n, MC); end
        n_cmp++; if (hi !== 32'hFFFF_FFFE) begin n_bad++; $display("FAIL multu_hi: got %h want fffffffe", hi); end
        n_cmp++; if (lo !== 32'h0000_0001) begin n_bad++; $display("FAIL multu_lo: got %h want 00000001", lo); end
    endtask

    task automatic test_div();
        int n;
        issue(3'd2, 32'hFFFF_FFF9, 32'd2);
        run_idle(n);
        n_cmp++; if (n != DC) begin n_bad++; $display("FAIL div_busy_len: got %0d want %0d", n, DC); end
        n_cmp++; if (lo !== 32'hFFFF_FFFD) begin n_bad++; $display("FAIL div_lo: got %h want fffffffd", lo); end
        n_cmp++; if (hi !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL div_hi: got %h want ffffffff", hi); end
        issue(3'd3, 32'd7, 32'd0);
        run_idle(n);
        n_cmp++; if (n != DC) begin n_bad++; $display("FAIL divz_busy_len: got %0d want %0d", n, DC); end
        n_cmp++; if (lo !== 32'hFFFF_FFFD) begin n_bad++; $display("FAIL divz_lo: got %h want fffffffd", lo); end
        n_cmp++; if (hi !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL divz_hi: got %h want ffffffff", hi); end
        issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        run_idle(n);
        n_cmp++; if (lo !== 32'h8000_0000) begin n_bad++; $display("FAIL divovf_lo: got %h want 80000000", lo); end
        n_cmp++; if (hi !== 32'h0) begin n_bad++; $display("FAIL divovf_hi: got %h want 0", hi); end
    endtask

    task automatic test_stall();
        int guard;
        md_use_D = 1'b1;
        #1;
        n_cmp++; if (stall_req !== 1'b0) begin n_bad++; $display("FAIL stall_idle: got %b want 0", stall_req); end
        start = 1'b1; op = 3'd0; a = $urandom; b = $urandom;
        #1;
        n_cmp++; if (stall_req !== 1'b1) begin n_bad++; $display("FAIL stall_start_cycle: got %b want 1", stall_req); end
        step();
        start = 1'b0;
        guard = 0;
        while (busy === 1'b1 && guard < 40) begin
            #1;
            n_cmp++; if (stall_req !== 1'b1) begin n_bad++; $display("FAIL stall_busy: got %b want 1", stall_req); end
            step();
            guard++;
        end
        n_cmp++; if (guard != MC) begin n_bad++; $display("FAIL stall_busy_len: got %0d want %0d", guard, MC); end
        n_cmp++; if (stall_req !== 1'b0) begin n_bad++; $display("FAIL stall_release: got %b want 0", stall_req); end
        n_cmp++; if (hi !== m_hi || lo !== m_lo) begin n_bad++; $display("FAIL stall_result: got %h_%h want %h_%h", hi, lo, m_hi, m_lo); end
        md_use_D = 1'b0;
        start = 1'b1; op = 3'd1; a = $urandom; b = $urandom;
        #1;
        n_cmp++; if (stall_req !== 1'b0) begin n_bad++; $display("FAIL nostall_start: got %b want 0", stall_req); end
        step();
        start = 1'b0;
        for (int i = 0; i < int'(MC); i++) begin
            n_cmp++; if (stall_req !== 1'b0) begin n_bad++; $display("FAIL nostall_busy: got %b want 0", stall_req); end
            step();
        end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL nostall_done: got %b want 0", busy); end
    endtask

    task automatic test_mtlo();
        logic [31:0] old_hi;
        old_hi = hi;
        issue(3'd5, 32'h0000_1234, 32'h0);
        n_cmp++; if (lo !== 32'h0000_1234) begin n_bad++; $display("FAIL mtlo_lo: got %h want 00001234", lo); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mtlo_busy: got %b want 0", busy); end
        n_cmp++; if (hi !== old_hi) begin n_bad++; $display("FAIL mtlo_hi: got %h want %h", hi, old_hi); end
        issue(3'd4, 32'hCAFE_F00D, 32'h0);
        n_cmp++; if (hi !== 32'hCAFE_F00D) begin n_bad++; $display("FAIL mthi_hi: got %h want cafef00d", hi); end
        issue(3'd6, 32'h1111_1111, 32'h2);
        issue(3'd7, 32'h3333_3333, 32'h4);
        n_cmp++; if (busy !== 1'b0 || hi !== 32'hCAFE_F00D || lo !== 32'h0000_1234) begin
            n_bad++; $display("FAIL undef_op: got busy=%b %h_%h want 0 cafef00d_00001234", busy, hi, lo);
        end
    endtask

    task automatic test_start_while_busy();
        int n;
        issue(3'd0, 32'd3, 32'd4);
        step();
        issue(3'd4, 32'hDEAD_BEEF, 32'h0);
        n_cmp++; if (hi !== 32'hCAFE_F00D) begin n_bad++; $display("FAIL busy_mthi: got %h want cafef00d", hi); end
        issue(3'd2, 32'd100, 32'd3);
        run_idle(n);
        n_cmp++; if (hi !== 32'h0 || lo !== 32'd12) begin n_bad++; $display("FAIL busy_result: got %h_%h want 0_0000000c", hi, lo); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL busy_ignored_div: got %b want 0", busy); end
    endtask

    task automatic test_reset_abort();
        issue(3'd0, 32'd7, 32'd9);
        for (int i = 0; i < int'(MC); i++) step();
        issue(3'd2, 32'd100, 32'd7);
        step(); step(); step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy: got %b want 0", busy); end
        n_cmp++; if (hi !== 32'h0 || lo !== 32'h0) begin n_bad++; $display("FAIL abort_hilo: got %h_%h want 0_0", hi, lo); end
        for (int i = 0; i < int'(DC) + 2; i++) step();
        n_cmp++; if (hi !== 32'h0 || lo !== 32'h0 || busy !== 1'b0) begin
            n_bad++; $display("FAIL abort_late_write: got busy=%b %h_%h want 0 0_0", busy, hi, lo);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            reset    = ($urandom_range(99) == 0);
            start    = ($urandom_range(2) == 0);
            op       = 3'($urandom_range(7));
            a        = $urandom;
            b        = $urandom;
            md_use_D = $urandom_range(1);
            case ($urandom_range(15))
                0: b = '0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(9));
                default: ;
            endcase
            #1;
            n_cmp++; if (stall_req !== exp_stall()) begin n_bad++; $display("FAIL rand_stall[%0d]: got %b want %b", i, stall_req, exp_stall()); end
            step();
            n_cmp++; if (busy !== (m_left > 0)) begin n_bad++; $display("FAIL rand_busy[%0d]: got %b want %b", i, busy, (m_left > 0)); end
            n_cmp++; if (hi !== m_hi || lo !== m_lo) begin n_bad++; $display("FAIL rand_hilo[%0d]: got %h_%h want %h_%h", i, hi, lo, m_hi, m_lo); end
        end
        reset = 1'b0;
        start = 1'b0;
    endtask

    initial begin
        m_hi = '0; m_lo = '0; m_phi = '0; m_plo = '0; m_pwe = 1'b0; m_left = 0;
        reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0; md_use_D = 1'b0;
        #1;
        test_reset();
        test_mult();
        test_multu();
        test_div();
        test_stall();
        test_mtlo();
        test_start_while_busy();
        test_reset_abort();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
